// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin packet scheduler sharing one uart_tx between
// NREQ requesters. Each grant emits a framed packet (header, payload hi,
// payload lo) byte by byte through tx_start / tx_done_tick, with a per-byte
// watchdog that aborts the packet if tx_done_tick never arrives.
// Optional feature macro: UART_SCHED_CHECKSUM_EN appends byte3 = b0^b1^b2.
module uart_tx_sched #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 40000,
  parameter int TO_W    = 16
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done_tick,
  output logic                 err_timeout
);

`ifdef UART_SCHED_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]      PTR_MAX = 2'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        ptr_r;
  logic [1:0]        idx_r;
  logic [1:0]        win_r;
  logic [15:0]       data_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [NREQ-1:0]   grant_r;
  logic              busy_r;
  logic              tx_start_r;
  logic [7:0]        tx_data_r;
  logic              err_timeout_r;

  logic              found_s;
  logic [1:0]        win_s;
  logic              last_byte_s;
  logic              to_hit_s;

`ifdef UART_SCHED_CHECKSUM_EN
  // XOR of the three data-bearing bytes of the frame.
  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                input logic [15:0] d);
    frame_checksum = hdr ^ d[15:8] ^ d[7:0];
  endfunction
`endif

  // Byte sel of the frame for winner w carrying payload d.
  function automatic logic [7:0] frame_byte(input logic [1:0]  sel,
                                            input logic [1:0]  w,
                                            input logic [15:0] d);
    logic [7:0] hdr;
    hdr = {4'hA, 2'b00, w};
    case (sel)
      2'd0:    frame_byte = hdr;
      2'd1:    frame_byte = d[15:8];
      2'd2:    frame_byte = d[7:0];
`ifdef UART_SCHED_CHECKSUM_EN
      2'd3:    frame_byte = frame_checksum(hdr, d);
`endif
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign last_byte_s = (idx_r == LAST_IDX);
  assign to_hit_s    = (to_cnt_r == TO_LAST);

  // Round-robin search: lowest offset from ptr_r with req set wins
  // (scan from the far end so nearer candidates overwrite farther ones).
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_r) + k) % NREQ]) begin
        found_s = 1'b1;
        win_s   = 2'((int'(ptr_r) + k) % NREQ);
      end else begin
        found_s = found_s;
        win_s   = win_s;
      end
    end
  end

  // Next-state logic; tx_done_tick has priority over the watchdog.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req) state_nx_s = ARB;
        else      state_nx_s = IDLE;
      end
      ARB: begin
        if (found_s) state_nx_s = SEND;
        else         state_nx_s = IDLE;
      end
      SEND: state_nx_s = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (last_byte_s) state_nx_s = IDLE;
          else             state_nx_s = SEND;
        end else if (to_hit_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Datapath and registered outputs; pulses default low every cycle.
  always_ff @(posedge pclk) begin
    if (rst) begin
      ptr_r         <= 2'd0;
      idx_r         <= 2'd0;
      win_r         <= 2'd0;
      data_r        <= 16'h0000;
      to_cnt_r      <= '0;
      grant_r       <= '0;
      busy_r        <= 1'b0;
      tx_start_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      err_timeout_r <= 1'b0;
    end else begin
      grant_r       <= '0;
      tx_start_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        ARB: begin
          if (found_s) begin
            grant_r[win_s] <= 1'b1;
            data_r         <= req_data[{win_s, 4'b0000} +: 16];
            win_r          <= win_s;
            busy_r         <= 1'b1;
            idx_r          <= 2'd0;
            ptr_r          <= (win_s == PTR_MAX) ? 2'd0 : win_s + 2'd1;
          end
        end
        SEND: begin
          tx_data_r  <= frame_byte(idx_r, win_r, data_r);
          tx_start_r <= 1'b1;
          to_cnt_r   <= '0;
        end
        WAIT: begin
          if (tx_done_tick) begin
            if (last_byte_s) busy_r <= 1'b0;
            else             idx_r  <= idx_r + 2'd1;
          end else if (to_hit_s) begin
            err_timeout_r <= 1'b1;
            busy_r        <= 1'b0;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign busy        = busy_r;
  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected grants and frame bytes are
// queued when requests are driven and popped when the DUT emits them.
module tb_uart_tx_sched;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 100;
`ifdef UART_SCHED_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [2:0]  req  = 3'b000;
  logic [47:0] req_data = 48'h0;
  logic        tx_done_tick = 1'b0;
  logic [2:0]  grant;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        err_timeout;

  uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .pclk(pclk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(tx_done_tick), .err_timeout(err_timeout)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_byte_q[$];
  logic [2:0] exp_grant_q[$];
  int  model_ptr = 0;
  bit  resp_en   = 1'b1;
  int  resp_cnt  = 0;
  int  done_cnt  = 0;
  int  start_cnt = 0;
  int  grant_cnt = 0;
  int  err_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Queue grant and the first nb frame bytes for winner w, advance rr model.
  task automatic expect_packet(input int w, input logic [15:0] d, input int nb);
    logic [7:0] b[4];
    logic [2:0] g;
    g = 3'b001 << w;
    b[0] = {4'hA, 2'b00, 2'(w)};
    b[1] = d[15:8];
    b[2] = d[7:0];
    b[3] = b[0] ^ b[1] ^ b[2];
    exp_grant_q.push_back(g);
    for (int i = 0; i < nb; i++) exp_byte_q.push_back(b[i]);
    model_ptr = (w + 1) % NREQ;
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge pclk) begin
    if (grant !== 3'b000) begin
      grant_cnt++;
      if (exp_grant_q.size() == 0) check("grant_unexpected", {29'd0, grant}, 32'd0);
      else check("grant", {29'd0, grant}, {29'd0, exp_grant_q.pop_front()});
    end
    if (tx_start === 1'b1) begin
      start_cnt++;
      if (exp_byte_q.size() == 0) check("tx_start_unexpected", {24'd0, tx_data}, 32'hFFFF);
      else check("tx_data", {24'd0, tx_data}, {24'd0, exp_byte_q.pop_front()});
    end
    if (err_timeout === 1'b1) err_cnt++;
  end

  // uart_tx model: answers each tx_start with tx_done_tick 3 cycles later.
  always @(negedge pclk) begin
    tx_done_tick = 1'b0;
    if (rst) begin
      resp_cnt = 0;
    end else if (tx_start === 1'b1 && resp_en) begin
      resp_cnt = 3;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        tx_done_tick = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge pclk);
      n++;
      if (grant !== 3'b000) break;
    end
    if (grant === 3'b000) check("grant_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge pclk);
      n++;
      if (tx_start === 1'b1) break;
    end
    if (tx_start !== 1'b1) check("start_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_err(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge pclk);
      n++;
      if (err_timeout === 1'b1) break;
    end
    if (err_timeout !== 1'b1) check("err_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge pclk);
      n++;
    end
    if (busy !== 1'b0) check("idle_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {29'd0, grant}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  initial begin
    int n, w, d0, gc, sc;
    logic [15:0] d;
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge pclk);

    // 1: single packet, latency and busy span
    req_data[15:0] = 16'h1234;
    expect_packet(rr_pick(3'b001), 16'h1234, NBYTES);
    req = 3'b001;
    d0 = done_cnt;
    wait_grant(n);
    check("t1_grant_latency", n, 2);
    check("t1_busy_at_grant", {31'd0, busy}, 32'd1);
    req = 3'b000;
    wait_start(n);
    check("t1_start_latency", n, 1);
    wait_idle();
    check("t1_dones_in_packet", done_cnt - d0, NBYTES);

    // 2: round-robin with all requests held
    do_reset();
    req_data = {16'h3333, 16'h2222, 16'h1111};
    for (int p = 0; p < 4; p++) begin
      w = rr_pick(3'b111);
      d = req_data[16*w +: 16];
      expect_packet(w, d, NBYTES);
    end
    req = 3'b111;
    for (int p = 0; p < 4; p++) begin
      wait_grant(n);
      if (p == 3) req = 3'b000;
    end
    wait_idle();

    // 3: watchdog abort, then normal service
    resp_en = 1'b0;
    req_data[31:16] = 16'h5A5A;
    expect_packet(rr_pick(3'b010), 16'h5A5A, 1);
    req = 3'b010;
    wait_grant(n);
    req = 3'b000;
    wait_start(n);
    wait_err(n);
    check("t3_timeout_latency", n, TIMEOUT);
    check("t3_busy_after_abort", {31'd0, busy}, 32'd0);
    resp_en = 1'b1;
    @(negedge pclk);
    check("t3_err_one_cycle", {31'd0, err_timeout}, 32'd0);
    req_data[47:32] = 16'hC3E1;
    expect_packet(rr_pick(3'b100), 16'hC3E1, NBYTES);
    req = 3'b100;
    wait_grant(n);
    req = 3'b000;
    wait_idle();

    // 4: one-cycle request withdrawn before arbitration
    gc = grant_cnt;
    sc = start_cnt;
    req = 3'b001;
    @(negedge pclk);
    req = 3'b000;
    repeat (10) @(negedge pclk);
    check("t4_no_grant", grant_cnt, gc);
    check("t4_no_start", start_cnt, sc);
    check("t4_not_busy", {31'd0, busy}, 32'd0);

    // 5: reset after the second tx_start
    req_data[15:0] = 16'h5678;
    expect_packet(rr_pick(3'b001), 16'h5678, 2);
    req = 3'b001;
    wait_grant(n);
    req = 3'b000;
    wait_start(n);
    wait_start(n);
    rst = 1'b1;
    @(negedge pclk);
    check_all_zero("t5_midreset");
    sc = start_cnt;
    @(negedge pclk);
    rst = 1'b0;
    model_ptr = 0;
    repeat (10) @(negedge pclk);
    check("t5_no_start_after_reset", start_cnt, sc);
    req_data[31:16] = 16'h9ABC;
    expect_packet(rr_pick(3'b010), 16'h9ABC, NBYTES);
    req = 3'b010;
    wait_grant(n);
    check("t5_grant_after_reset", {29'd0, grant}, 32'd2);
    req = 3'b000;
    wait_idle();

    // 6: payload changed right after grant must not leak into the frame
    req_data[15:0] = 16'hABCD;
    expect_packet(rr_pick(3'b001), 16'hABCD, NBYTES);
    req = 3'b001;
    wait_grant(n);
    req_data[15:0] = 16'hFFFF;
    req = 3'b000;
    wait_idle();

    repeat (5) @(negedge pclk);
    check("byte_queue_drained", exp_byte_q.size(), 0);
    check("grant_queue_drained", exp_grant_q.size(), 0);
    check("err_pulse_count", err_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got=expired expected=finished");
    $fatal(1, "time limit");
  end

endmodule
